// File: rtl/nway_cache_pkg.sv
// Shared types and constants for the N-way set-associative L1 cache.
// Controller states are plain encoded constants so legacy tools can read them.
package nway_cache_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;

  typedef logic [1:0] cache_state_t;

  localparam cache_state_t IDLE      = 2'd0;
  localparam cache_state_t WRITEBACK = 2'd1;
  localparam cache_state_t ALLOCATE  = 2'd2;

endpackage

// File: rtl/nway_cache_plru_tree.sv
// Combinational tree pseudo-LRU: picks a victim way and computes the updated
// node bits for an access. Node n has children 2n+1 (left) and 2n+2 (right).
module plru_tree #(
  parameter int WAYS = 4
) (
  input  logic [$clog2(WAYS)-1:0] access_way,
  input  logic                    access_en,
  input  logic [WAYS-2:0]         plru_bits_in,
  output logic [$clog2(WAYS)-1:0] victim_way,
  output logic [WAYS-2:0]         plru_bits_out
);

  localparam int LEVELS = $clog2(WAYS);

  // A node bit of 0 sends the victim search into the lower-index subtree.
  always_comb begin : victim_walk
    int node;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      node = plru_bits_in[node] ? 2 * node + 2 : 2 * node + 1;
    end
    victim_way = LEVELS'(node - (WAYS - 1));
  end

  always_comb begin : access_update
    int node;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    plru_bits_out = plru_bits_in;
    node          = 0;
    if (access_en) begin
      for (int l = 0; l < LEVELS; l++) begin
        plru_bits_out[node] = ~access_way[LEVELS-1-l];
        node = 2 * node + 1 + int'(access_way[LEVELS-1-l]);
      end
    end
  end

endmodule

// File: rtl/nway_cache.sv
// Write-back, write-allocate N-way set-associative L1 cache between the 16-bit
// core port and a line-wide physical memory, with 0-cycle hits.
module nway_cache
  import nway_cache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       mem_address,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [1:0]              mem_byte_enable,
  input  logic [WORD_W-1:0]       mem_wdata,
  output logic [WORD_W-1:0]       mem_rdata,
  output logic                    mem_resp,
  output logic [ADDR_W-1:0]       pmem_address,
  output logic                    pmem_read,
  output logic                    pmem_write,
  output logic [8*LINE_BYTES-1:0] pmem_wdata,
  input  logic [8*LINE_BYTES-1:0] pmem_rdata,
  input  logic                    pmem_resp
);

  localparam int INDEX_W  = $clog2(SETS);
  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W   = 8 * LINE_BYTES;
  localparam int WAY_W    = $clog2(WAYS);
  localparam int WSEL_W   = OFFSET_W - 1;

  cache_state_t state, next_state;

  logic [TAG_W-1:0]   tag, tag_q;
  logic [INDEX_W-1:0] idx, idx_q, rd_idx;
  logic [WSEL_W-1:0]  word;
  logic               unused_addr_bit;

  logic [WAYS-1:0]    valid [SETS];
  logic [WAYS-1:0]    dirty [SETS];
  logic [WAYS-2:0]    plru  [SETS];

  logic [TAG_W-1:0]   rd_tag  [WAYS];
  logic [LINE_W-1:0]  rd_line [WAYS];
  logic [WAYS-1:0]    hit_vec, line_we, tag_we;
  logic [LINE_W-1:0]  hit_line, merged_line, wr_line;

  logic [WAY_W-1:0]   hit_way, victim, victim_q, plru_victim, plru_way;
  logic [WAYS-2:0]    plru_out;
  logic               hit, req, wr_hit, fill, wb_done, plru_en, miss_start;

  assign tag             = mem_address[ADDR_W-1 -: TAG_W];
  assign idx             = mem_address[OFFSET_W +: INDEX_W];
  assign word            = mem_address[1 +: WSEL_W];
  assign unused_addr_bit = mem_address[0];

  // Outside IDLE the arrays are addressed by the latched miss set.
  assign rd_idx = (state == IDLE) ? idx : idx_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0]  tag_arr  [SETS];
    logic [LINE_W-1:0] line_arr [SETS];

    // NOTE: tag and data storage is deliberately not reset; valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
      if (tag_we[w])  tag_arr[rd_idx]  <= tag_q;
      if (line_we[w]) line_arr[rd_idx] <= wr_line;
    end

    assign rd_tag[w]  = tag_arr[rd_idx];
    assign rd_line[w] = line_arr[rd_idx];
    assign hit_vec[w] = valid[idx][w] && (tag_arr[idx] == tag);
  end

  always_comb begin
    hit     = |hit_vec;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  // Lowest-index invalid way wins over the PLRU choice.
  always_comb begin
    victim = plru_victim;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) victim = WAY_W'(w);
    end
  end

  assign hit_line  = rd_line[hit_way];
  assign mem_rdata = hit_line[{word, 4'h0} +: WORD_W];

  always_comb begin
    merged_line = hit_line;
    if (mem_byte_enable[0]) merged_line[{word, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged_line[{word, 4'h8} +: 8] = mem_wdata[15:8];
  end

  assign req = (mem_read | mem_write) & ~reset;

  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    wr_hit       = 1'b0;
    fill         = 1'b0;
    wb_done      = 1'b0;
    miss_start   = 1'b0;
    plru_en      = 1'b0;
    plru_way     = hit_way;
    case (state)
      IDLE: begin
        if (req && hit) begin
          mem_resp = 1'b1;
          wr_hit   = mem_write;
          plru_en  = 1'b1;
        end else if (req) begin
          miss_start = 1'b1;
          next_state = dirty[idx][victim] ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {rd_tag[victim_q], idx_q, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          wb_done    = 1'b1;
          next_state = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {tag_q, idx_q, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          fill       = 1'b1;
          plru_en    = 1'b1;
          plru_way   = victim_q;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign wr_line    = fill ? pmem_rdata : merged_line;
  assign tag_we     = fill ? (WAYS'(1) << victim_q) : '0;
  assign line_we    = fill ? (WAYS'(1) << victim_q)
                    : (wr_hit ? (WAYS'(1) << hit_way) : '0);
  assign pmem_wdata = rd_line[victim_q];

  plru_tree #(.WAYS(WAYS)) u_plru (
    .access_way    (plru_way),
    .access_en     (plru_en),
    .plru_bits_in  (plru[rd_idx]),
    .victim_way    (plru_victim),
    .plru_bits_out (plru_out)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        plru[s]  <= '0;
      end
    end else begin
      state <= next_state;
      if (miss_start) begin
        victim_q <= victim;
        tag_q    <= tag;
        idx_q    <= idx;
      end
      if (wr_hit)  dirty[idx][hit_way]    <= 1'b1;
      if (wb_done) dirty[idx_q][victim_q] <= 1'b0;
      if (fill) begin
        valid[idx_q][victim_q] <= 1'b1;
        dirty[idx_q][victim_q] <= 1'b0;
      end
      if (plru_en) plru[rd_idx] <= plru_out;
    end
  end

endmodule
